// File: rtl/fifo_stream_pkg.sv
// Shared types and defaults for the FIFO read-side stream adapter.
package fifo_stream_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PKT_LEN    = 4;

  // Number of valid words held in the 2-entry output buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-ordered output buffer with its occupancy FSM.
// The head entry is always the word being presented downstream.
module fifo_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output occ_e                  occ_o
);

  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  // State and storage registers; storage is cleared so the stream data reads 0 out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Occupancy transitions and entry movement for push/pop combinations.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push_i) begin
          head_d = data_i;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({push_i, pop_i})
          2'b10: begin
            tail_d = data_i;
            occ_d  = OCC_TWO;
          end
          // Head leaves and the arriving word goes straight into the head slot.
          2'b11: head_d = data_i;
          2'b01: occ_d  = OCC_EMPTY;
          default: ;
        endcase
      end
      OCC_TWO: begin
        // push without pop is prevented upstream by the read-enable throttle.
        if (pop_i) begin
          head_d = tail_q;
          if (push_i) tail_d = data_i;
          else        occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  assign valid_o = (occ_q != OCC_EMPTY);
  assign data_o  = head_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the async FIFO: pops words, hides the 1-cycle read
// latency behind a 2-entry buffer and presents a valid/ready packet stream.
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PKT_LEN    = DEF_PKT_LEN
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  output logic                       fifo_r_en,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_last,
  output logic [$clog2(PKT_LEN):0]   beat_idx
);

  localparam int                BEAT_W    = $clog2(PKT_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic              infl_q, infl_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              pop;
  logic [2:0]        level;
  occ_e              occ;

  assign pop = m_valid && m_ready;

  // Words held plus the word arriving this cycle; read only when the result
  // after this cycle's pop still leaves room for the word being requested now.
  assign level     = {1'b0, occ} + {2'b00, infl_q};
  assign fifo_r_en = !rrst && !fifo_empty && (level <= (3'd1 + {2'b00, pop}));
  assign infl_d    = fifo_r_en && !fifo_empty;

  // Beat index advances on each accepted word and wraps at the packet end.
  always_comb begin
    beat_d = beat_q;
    if (pop) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
  end

  // In-flight flag and beat counter; reset discards any word already requested.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      infl_q <= 1'b0;
      beat_q <= '0;
    end else begin
      infl_q <= infl_d;
      beat_q <= beat_d;
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i   (rclk),
    .rst_i   (rrst),
    .push_i  (infl_q),
    .data_i  (fifo_data),
    .pop_i   (pop),
    .valid_o (m_valid),
    .data_o  (m_data),
    .occ_o   (occ)
  );

  assign m_last   = m_valid && (beat_q == LAST_BEAT);
  assign beat_idx = beat_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a behavioural FIFO read port.
module tb_fifo_rd_stream;

  localparam int DW      = 8;
  localparam int PKT_LEN = 4;
  localparam int BW      = $clog2(PKT_LEN) + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [BW-1:0] beat;
  } exp_t;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_r_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [BW-1:0] beat_idx;

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PKT_LEN)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .beat_idx   (beat_idx)
  );

  always #5 rclk = ~rclk;

  // FIFO model state
  logic [DW-1:0] mem[$];
  logic [DW-1:0] wr_req[$];
  logic          clr_req = 1'b0;

  // Scoreboard and request flags (written by stimulus, read by monitor)
  exp_t          exp_q[$];
  int            pkt_pos = 0;
  logic          chk_reset = 0, chk_ren1 = 0, chk_noren = 0, chk_hold = 0;
  logic          chk_occ2 = 0, chk_nvalid = 0, chk_cnt = 0, chk_drain = 0;
  logic          consec_arm = 0;
  logic [DW-1:0] hold_val = '0;
  int            exp_ren = 0, exp_vld = 0;

  // Monitor-owned counters
  int            n_chk = 0, n_fail = 0;
  int            ren_cnt = 0, vld_cnt = 0, acc_cnt = 0;
  int            consec_cnt = 0;
  logic          consec_done = 0;
  logic          stall_q = 0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 0;
  logic [BW-1:0] stall_beat = '0;

  // Behavioural FIFO: data appears one cycle after a read of a non-empty FIFO.
  always @(posedge rclk) begin
    if (clr_req) begin
      mem.delete();
      wr_req.delete();
    end else if (fifo_r_en && !fifo_empty) begin
      fifo_data <= mem.pop_front();
    end
    while (wr_req.size() > 0) mem.push_back(wr_req.pop_front());
    fifo_empty <= (mem.size() == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge rclk) begin
    exp_t e;
    if (chk_reset) begin
      chk("rst_r_en", fifo_r_en, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_beat", beat_idx, 0);
      chk("rst_last", m_last, 0);
    end
    if (chk_ren1)   chk("r_en_after_release", fifo_r_en, 1);
    if (chk_noren)  chk("r_en_when_full", fifo_r_en, 0);
    if (chk_hold) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, hold_val);
    end
    if (chk_occ2)   chk("occupancy_two", dut.occ, 2);
    if (chk_nvalid) chk("valid_after_reset", m_valid, 0);
    if (chk_cnt) begin
      chk("r_en_pulses", ren_cnt, exp_ren);
      chk("valid_cycles", vld_cnt, exp_vld);
    end
    if (fifo_empty) chk("r_en_while_empty", fifo_r_en, 0);
    if (consec_arm && !consec_done && (m_valid || consec_cnt > 0)) begin
      chk("consecutive_valid", m_valid, 1);
      consec_cnt++;
      if (consec_cnt == 8) consec_done = 1;
    end
    if (!rrst) begin
      if (fifo_r_en && !fifo_empty) ren_cnt++;
      if (m_valid) vld_cnt++;
      if (stall_q) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, stall_data);
        chk("stall_last", m_last, stall_last);
        chk("stall_beat", beat_idx, stall_beat);
      end
      if (m_valid && m_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected none at %0t", m_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("data", m_data, e.data);
          chk("last", m_last, e.last);
          chk("beat", beat_idx, e.beat);
        end
      end
      stall_q    = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
      stall_beat = beat_idx;
    end else begin
      stall_q = 0;
    end
    if (chk_drain) chk("drain_remaining", exp_q.size(), 0);
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.last = (pkt_pos == PKT_LEN - 1);
    e.beat = BW'(pkt_pos);
    exp_q.push_back(e);
    wr_req.push_back(d);
    pkt_pos = (pkt_pos == PKT_LEN - 1) ? 0 : pkt_pos + 1;
  endtask

  task automatic do_reset();
    rrst    = 1'b1;
    m_ready = 1'b0;
    clr_req = 1'b1;
    exp_q.delete();
    pkt_pos = 0;
    tick();
    tick();
    clr_req = 1'b0;
    rrst    = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) tick();
    chk_drain = 1'b1;
    tick();
    chk_drain = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] stream_v[8];
    stream_v = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};

    // Reset with a non-empty FIFO, then stream 0x11..0x18 at full rate.
    rrst    = 1'b1;
    m_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 8; i++) push_word(stream_v[i]);
    tick();
    chk_reset = 1'b1;
    tick();
    chk_reset  = 1'b0;
    consec_arm = 1'b1;
    rrst       = 1'b0;
    chk_ren1   = 1'b1;
    tick();
    chk_ren1 = 1'b0;
    wait_drain(40);
    consec_arm = 1'b0;

    // Backpressure: hold m_ready low for 5 cycles once the first word shows.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(stream_v[i]);
    for (int i = 0; i < 10 && !m_valid; i++) tick();
    hold_val  = 8'h11;
    chk_hold  = 1'b1;
    chk_noren = 1'b1;
    tick();
    chk_occ2 = 1'b1;
    tick();
    chk_occ2 = 1'b0;
    tick();
    tick();
    tick();
    chk_hold  = 1'b0;
    chk_noren = 1'b0;
    m_ready   = 1'b1;
    wait_drain(40);

    // Single word through an otherwise empty FIFO.
    do_reset();
    m_ready = 1'b1;
    tick();
    exp_ren = ren_cnt + 1;
    exp_vld = vld_cnt + 1;
    push_word(8'hA5);
    for (int i = 0; i < 8; i++) tick();
    chk_cnt = 1'b1;
    tick();
    chk_cnt = 1'b0;
    wait_drain(5);

    // Alternating ready over 12 words; beat index wraps twice.
    do_reset();
    for (int i = 0; i < 12; i++) push_word(DW'(8'h20 + i));
    for (int i = 0; i < 80 && exp_q.size() > 0; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    m_ready = 1'b1;
    wait_drain(10);

    // Reset in the middle of a packet; the following word starts a new packet.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(DW'(8'h31 + i));
    begin
      int base;
      base = acc_cnt;
      for (int i = 0; i < 20 && acc_cnt < base + 2; i++) tick();
    end
    rrst    = 1'b1;
    m_ready = 1'b0;
    clr_req = 1'b1;
    exp_q.delete();
    pkt_pos = 0;
    tick();
    rrst       = 1'b0;
    clr_req    = 1'b0;
    chk_nvalid = 1'b1;
    tick();
    chk_nvalid = 1'b0;
    m_ready    = 1'b1;
    for (int i = 0; i < 4; i++) push_word(DW'(8'h41 + i));
    wait_drain(30);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
